ifid_pipe_reg: RTL

- Parametrised IF/ID pipeline stage carrying {instruction, instruction address} from fetch to decode.
- Adds a valid/ready handshake, stall back-pressure and flush that injects a NOP bubble.
- Optional two-entry skid buffer breaks the combinational ready path from decode back to fetch.
- Used between IF and ID. Can be re-instantiated for other stages by changing widths.

---
 rtl/ifid_pipe_reg_if.sv | 27 ++
 rtl/ifid_pipe_reg.sv | 105 ++++++++++
 2 files changed

// File: rtl/ifid_pipe_reg_if.sv
// IF/ID stage bundle: fetch-side handshake, decode-side handshake, flush and occupancy.
// master = fetch/decode environment, slave = the pipeline stage.
interface ifid_pipe_reg_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned ADDR_W  = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  instr_address;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] instruction_out;
    logic [ADDR_W-1:0]  instr_address_out;
    logic [1:0]         occupancy;

    modport master (
        output in_valid, instruction, instr_address, flush, out_ready,
        input  in_ready, out_valid, instruction_out, instr_address_out, occupancy
    );

    modport slave (
        input  in_valid, instruction, instr_address, flush, out_ready,
        output in_ready, out_valid, instruction_out, instr_address_out, occupancy
    );
endinterface

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush-to-bubble and an
// optional skid entry that registers in_ready to cut the decode->fetch ready path.
module ifid_pipe_reg #(
    parameter int unsigned INSTR_W   = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned SKID      = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           reset_n,
    ifid_pipe_reg_if.slave bus
);
    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

    logic               head_valid_q, head_valid_d;
    logic [INSTR_W-1:0] head_instr_q, head_instr_d;
    logic [ADDR_W-1:0]  head_addr_q,  head_addr_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_addr_q,  skid_addr_d;
    logic               in_ready_q,   in_ready_d;

    logic in_ready;
    logic in_xfer;
    logic head_load;
    logic skid_load;
    logic skid_to_head;

    assign in_ready = (SKID != 0) ? in_ready_q : (!head_valid_q || bus.out_ready);
    assign in_xfer  = bus.in_valid && in_ready;

    // Skid is only ever filled while the head is stalled, so with the skid full
    // in_ready is low and no new entry can compete with the skid->head move.
    always_comb begin
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_load    = 1'b0;
        skid_load    = 1'b0;
        skid_to_head = 1'b0;
        if (bus.flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (bus.out_ready) begin
                skid_to_head = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (head_valid_q && !bus.out_ready) begin
            if (in_xfer && (SKID != 0)) begin
                skid_load    = 1'b1;
                skid_valid_d = 1'b1;
            end
        end else if (in_xfer) begin
            head_load    = 1'b1;
            head_valid_d = 1'b1;
        end else if (head_valid_q) begin
            head_valid_d = 1'b0;
        end
    end

    always_comb begin
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;
        if (head_load) begin
            head_instr_d = bus.instruction;
            head_addr_d  = bus.instr_address;
        end else if (skid_to_head) begin
            head_instr_d = skid_instr_q;
            head_addr_d  = skid_addr_q;
        end
        if (skid_load) begin
            skid_instr_d = bus.instruction;
            skid_addr_d  = bus.instr_address;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            head_instr_q <= '0;
            head_addr_q  <= '0;
            skid_instr_q <= '0;
            skid_addr_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.out_valid         = head_valid_q;
    assign bus.instruction_out   = head_valid_q ? head_instr_q : NOP_W;
    assign bus.instr_address_out = head_valid_q ? head_addr_q : '0;
    assign bus.occupancy         = {skid_valid_q, head_valid_q && !skid_valid_q};
endmodule
